// File: rtl/sl2_shifter.sv
// -----------------------------------------------------------------------------
// sl2_shifter
//   Fixed left shift by SHAMT bits (default 2, i.e. multiply by 4) used for
//   branch-offset and word-address scaling in the CPU datapath. Provides a
//   combinational result for in-cycle use and a one-cycle registered copy
//   with valid/overflow flags for pipelined consumers.
//
// Parameters:
//   N      operand/result width in bits (N >= 3)
//   SHAMT  fixed left-shift amount (0 <= SHAMT < N)
//
// Ports:
//   clk        rising-edge clock for the registered path
//   reset      synchronous reset, active-low (0 = reset asserted)
//   a          operand to shift
//   in_valid   qualifies a for capture into the registered path
//   y          combinational a << SHAMT, zero fill
//   ovf        combinational flag: any of the top SHAMT bits of a set
//   y_q        registered y (holds when in_valid is low)
//   ovf_q      registered ovf (holds when in_valid is low)
//   out_valid  registered in_valid
// -----------------------------------------------------------------------------
module sl2_shifter #(
  parameter int unsigned N     = 64,
  parameter int unsigned SHAMT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic         in_valid,
  output logic [N-1:0] y,
  output logic         ovf,
  output logic [N-1:0] y_q,
  output logic         ovf_q,
  output logic         out_valid
);

  // Mask of the top SHAMT bits of a. Built from a right-shifted all-ones
  // vector so SHAMT = 0 yields an empty mask rather than an illegal slice.
  localparam logic [N-1:0] ALL_ONES = '1;
  localparam logic [N-1:0] HI_MASK  = ~(ALL_ONES >> SHAMT);

  logic [N-1:0] y_q_d;
  logic         ovf_q_d;
  logic         out_valid_d;
  logic         out_valid_q;

  // Combinational path: logical shift, bits shifted out only raise ovf.
  always_comb begin
    y   = a << SHAMT;
    ovf = |(a & HI_MASK);
  end

  // Next-state for the registered path: capture on in_valid, otherwise hold
  // the data and drop the valid flag.
  always_comb begin
    y_q_d       = y_q;
    ovf_q_d     = ovf_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      y_q_d       = y;
      ovf_q_d     = ovf;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      y_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_q_d;
      ovf_q       <= ovf_q_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sl2_shifter.sv
// -----------------------------------------------------------------------------
// tb_sl2_shifter
//   Directed bench for sl2_shifter: a default N=64 instance and an N=8,
//   SHAMT=2 instance share clk/reset. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_sl2_shifter;

  logic        clk;
  logic        clk_en;
  logic        reset;

  logic [63:0] a;
  logic        in_valid;
  logic [63:0] y;
  logic        ovf;
  logic [63:0] y_q;
  logic        ovf_q;
  logic        out_valid;

  logic [7:0]  a8;
  logic        in_valid8;
  logic [7:0]  y8;
  logic        ovf8;
  logic [7:0]  y_q8;
  logic        ovf_q8;
  logic        out_valid8;

  int unsigned compared;
  int unsigned mismatched;

  sl2_shifter dut64 (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .in_valid  (in_valid),
    .y         (y),
    .ovf       (ovf),
    .y_q       (y_q),
    .ovf_q     (ovf_q),
    .out_valid (out_valid)
  );

  sl2_shifter #(.N(8), .SHAMT(2)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .a         (a8),
    .in_valid  (in_valid8),
    .y         (y8),
    .ovf       (ovf8),
    .y_q       (y_q8),
    .ovf_q     (ovf_q8),
    .out_valid (out_valid8)
  );

  // Clock stays low until enabled so the combinational checks see no edges.
  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    clk_en     = 1'b0;
    reset      = 1'b1;
    a          = '0;
    in_valid   = 1'b0;
    a8         = '0;
    in_valid8  = 1'b0;

    // Combinational, no clock
    a = 64'd1; #10;
    check("comb a=1 y", y, 64'd4);
    check("comb a=1 ovf", {63'd0, ovf}, 64'd0);
    a = 64'd4; #10;
    check("comb a=4 y", y, 64'd16);
    check("comb a=4 ovf", {63'd0, ovf}, 64'd0);
    a = 64'd5; #10;
    check("comb a=5 y", y, 64'd20);
    check("comb a=5 ovf", {63'd0, ovf}, 64'd0);

    // Combinational boundaries
    a = 64'd0; #10;
    check("comb zero y", y, 64'd0);
    check("comb zero ovf", {63'd0, ovf}, 64'd0);
    a = 64'hFFFF_FFFF_FFFF_FFFF; #10;
    check("comb ones y", y, 64'hFFFF_FFFF_FFFF_FFFC);
    check("comb ones ovf", {63'd0, ovf}, 64'd1);
    a = 64'h2000_0000_0000_0000; #10;
    check("comb msb y", y, 64'h8000_0000_0000_0000);
    check("comb msb ovf", {63'd0, ovf}, 64'd0);
    a = 64'h4000_0000_0000_0000; #10;
    check("comb lost y", y, 64'd0);
    check("comb lost ovf", {63'd0, ovf}, 64'd1);
    a = 64'h8000_0000_0000_0001; #10;
    check("comb top bit y", y, 64'd4);
    check("comb top bit ovf", {63'd0, ovf}, 64'd1);

    // Reset values
    reset  = 1'b0;
    clk_en = 1'b1;
    step();
    step();
    check("rst y_q", y_q, 64'd0);
    check("rst ovf_q", {63'd0, ovf_q}, 64'd0);
    check("rst out_valid", {63'd0, out_valid}, 64'd0);
    check("rst out_valid8", {63'd0, out_valid8}, 64'd0);

    // Registered path, back-to-back valid
    reset    = 1'b1;
    in_valid = 1'b1;
    a = 64'd3; step();
    check("reg a=3 y_q", y_q, 64'd12);
    check("reg a=3 out_valid", {63'd0, out_valid}, 64'd1);
    a = 64'd7; step();
    check("reg a=7 y_q", y_q, 64'd28);
    check("reg a=7 out_valid", {63'd0, out_valid}, 64'd1);
    a = 64'd9; step();
    check("reg a=9 y_q", y_q, 64'd36);
    check("reg a=9 out_valid", {63'd0, out_valid}, 64'd1);
    check("reg a=9 ovf_q", {63'd0, ovf_q}, 64'd0);

    // Idle: hold data, drop valid
    in_valid = 1'b0;
    a = 64'd5; step();
    check("idle out_valid", {63'd0, out_valid}, 64'd0);
    check("idle y_q hold", y_q, 64'd36);

    // Synchronous reset with in_valid high
    reset    = 1'b0;
    in_valid = 1'b1;
    a        = 64'd5;
    #3;
    check("rst no edge y_q", y_q, 64'd36);
    check("rst no edge out_valid", {63'd0, out_valid}, 64'd0);
    check("rst comb y", y, 64'd20);
    step();
    check("rst edge y_q", y_q, 64'd0);
    check("rst edge ovf_q", {63'd0, ovf_q}, 64'd0);
    check("rst edge out_valid", {63'd0, out_valid}, 64'd0);
    #3;
    check("rst held y_q", y_q, 64'd0);
    check("rst held out_valid", {63'd0, out_valid}, 64'd0);

    // Registered overflow capture
    reset = 1'b1;
    a     = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check("reg ones y_q", y_q, 64'hFFFF_FFFF_FFFF_FFFC);
    check("reg ones ovf_q", {63'd0, ovf_q}, 64'd1);
    in_valid = 1'b0;
    a = 64'd1; step();
    check("idle ovf_q hold", {63'd0, ovf_q}, 64'd1);

    // N=8 override
    a8 = 8'h3F; #2;
    check("n8 3F y", {56'd0, y8}, 64'hFC);
    check("n8 3F ovf", {63'd0, ovf8}, 64'd0);
    in_valid8 = 1'b1;
    step();
    check("n8 3F y_q", {56'd0, y_q8}, 64'hFC);
    check("n8 3F ovf_q", {63'd0, ovf_q8}, 64'd0);
    check("n8 3F out_valid", {63'd0, out_valid8}, 64'd1);
    a8 = 8'hC1; #2;
    check("n8 C1 y", {56'd0, y8}, 64'h04);
    check("n8 C1 ovf", {63'd0, ovf8}, 64'd1);
    step();
    check("n8 C1 y_q", {56'd0, y_q8}, 64'h04);
    check("n8 C1 ovf_q", {63'd0, ovf_q8}, 64'd1);
    in_valid8 = 1'b0;
    step();
    check("n8 idle out_valid", {63'd0, out_valid8}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
